multi_issue_instr_queue: RTL and testbench

MULTI_ISSUE_INSTR_QUEUE -- requirements
Module: multi_issue_instr_queue

---
 rtl/drac_pkg.sv | 19 +
 rtl/multi_issue_instr_queue_if.sv | 24 ++
 rtl/iq_ptr_ctrl.sv | 105 ++++++++++
 rtl/multi_issue_instr_queue.sv | 86 ++++++++
 tb/tb_multi_issue_instr_queue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/drac_pkg.sv
// Shared types and default sizing for the multi-issue instruction queue.
package drac_pkg;

    localparam int IQ_DEPTH = 8;
    localparam int IQ_LANES = 2;

    // Decoded-instruction record travelling from ID/IR into the issue queue.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        ex_valid;
    } id_ir_stage_t;

    // Width of an index selecting one of n items; never zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_issue_instr_queue_if.sv
// Enqueue/dequeue handshake bundle for multi_issue_instr_queue.
// The master side is the decode/issue logic; the slave side is the queue.
interface multi_issue_instr_queue_if #(
    parameter int LANES = drac_pkg::IQ_LANES
);

    logic                                 enq_ready_o;
    logic [LANES-1:0]                     enq_valid_i;
    drac_pkg::id_ir_stage_t [LANES-1:0]   enq_instr_i;
    logic [LANES-1:0]                     deq_valid_o;
    drac_pkg::id_ir_stage_t [LANES-1:0]   deq_instr_o;
    logic [LANES-1:0]                     deq_ready_i;

    modport master (
        output enq_valid_i, enq_instr_i, deq_ready_i,
        input  enq_ready_o, deq_valid_o, deq_instr_o
    );

    modport slave (
        input  enq_valid_i, enq_instr_i, deq_ready_i,
        output enq_ready_o, deq_valid_o, deq_instr_o
    );

endinterface

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/count bookkeeping for the instruction queue: lane packing offsets,
// popped-run length and modulo-DEPTH wrap. Bypass is compiled in with IQ_BYPASS_EN.
module iq_ptr_ctrl
    import drac_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    parameter  int LANES = IQ_LANES,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1,
    localparam int LW    = idx_width(LANES)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic [LANES-1:0]           enq_valid_i,
    input  logic [LANES-1:0]           deq_ready_i,
    output logic                       enq_ready_o,
    output logic                       bypass_o,
    output logic [LANES-1:0]           lane_valid_o,
    output logic [LANES-1:0]           wr_en_o,
    output logic [LANES-1:0][PW-1:0]   wr_idx_o,
    output logic [LANES-1:0][PW-1:0]   rd_idx_o,
    output logic [LANES-1:0][LW-1:0]   byp_src_o,
    output logic [CW-1:0]              count_o
);

    logic [PW-1:0]           head_q, tail_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           n_req, n_push, n_pop, skip;
    logic [LANES-1:0][CW-1:0] rank;
    logic                    run;

    // Same-cycle pops are not credited, so readiness depends on count alone.
    assign enq_ready_o = (CW'(DEPTH) - count_q) >= CW'(LANES);

`ifdef IQ_BYPASS_EN
    assign bypass_o = (count_q == '0) && !flush_i && rstn_i;
`else
    assign bypass_o = 1'b0;
`endif

    always_comb begin
        // NOTE: blocking '=' is intended here: n_req is a running sum and each
        // iteration must see the value the previous iteration just wrote.
        n_req = '0;
        rank  = '0;
        for (int j = 0; j < LANES; j++) begin
            rank[j] = n_req;
            if (enq_valid_i[j]) n_req = n_req + CW'(1);
        end
    end

    assign n_push = enq_ready_o ? n_req : '0;

    // Only the unbroken run of handshakes starting at lane 0 is consumed.
    always_comb begin
        lane_valid_o = '0;
        n_pop        = '0;
        run          = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            lane_valid_o[i] = rstn_i && (CW'(i) < (bypass_o ? n_push : count_q));
            if (run && lane_valid_o[i] && deq_ready_i[i]) n_pop = n_pop + CW'(1);
            else                                          run   = 1'b0;
        end
    end

    // Bypassed lanes that were consumed this cycle never reach storage.
    assign skip = bypass_o ? n_pop : '0;

    always_comb begin
        wr_en_o   = '0;
        wr_idx_o  = '0;
        rd_idx_o  = '0;
        byp_src_o = '0;
        for (int j = 0; j < LANES; j++) begin
            wr_en_o[j]  = rstn_i && !flush_i && enq_ready_o && enq_valid_i[j] && (rank[j] >= skip);
            wr_idx_o[j] = tail_q + PW'(rank[j] - skip);
        end
        for (int i = 0; i < LANES; i++) begin
            rd_idx_o[i] = head_q + PW'(i);
            for (int j = 0; j < LANES; j++) begin
                if (enq_valid_i[j] && (rank[j] == CW'(i))) byp_src_o[i] = LW'(j);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(n_pop - skip);
            tail_q  <= tail_q + PW'(n_push - skip);
            count_q <= count_q + n_push - n_pop;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multi_issue_instr_queue.sv
// Multi-issue instruction queue: circular storage with LANES-wide packed enqueue
// and in-order dequeue. Define IQ_BYPASS_EN for empty-queue combinational bypass.
module multi_issue_instr_queue
    import drac_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,   // power of two, >= 2*LANES
    parameter  int LANES = IQ_LANES,   // 1..4, must match the interface
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1,
    localparam int LW    = idx_width(LANES)
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    multi_issue_instr_queue_if.slave   iq,
    output logic [CW-1:0]              count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    logic                      enq_ready;
    logic                      bypass;
    logic [LANES-1:0]          lane_valid;
    logic [LANES-1:0]          wr_en;
    logic [LANES-1:0][PW-1:0]  wr_idx;
    logic [LANES-1:0][PW-1:0]  rd_idx;
    logic [LANES-1:0][LW-1:0]  byp_src;
    logic [CW-1:0]             count;

    id_ir_stage_t mem_q [DEPTH];

    iq_ptr_ctrl #(
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) u_ptr_ctrl (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .flush_i      (flush_i),
        .enq_valid_i  (iq.enq_valid_i),
        .deq_ready_i  (iq.deq_ready_i),
        .enq_ready_o  (enq_ready),
        .bypass_o     (bypass),
        .lane_valid_o (lane_valid),
        .wr_en_o      (wr_en),
        .wr_idx_o     (wr_idx),
        .rd_idx_o     (rd_idx),
        .byp_src_o    (byp_src),
        .count_o      (count)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: storage is intentionally not reset; validity comes from count,
        // so stale payload is never visible and the array stays plain RAM.
        for (int j = 0; j < LANES; j++) begin
            if (wr_en[j]) mem_q[wr_idx[j]] <= iq.enq_instr_i[j];
        end
    end

    always_comb begin
        // NOTE: each lane gets a zero default before the conditional, which
        // keeps this block purely combinational (no latch).
        iq.deq_instr_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid[i]) begin
`ifdef IQ_BYPASS_EN
                iq.deq_instr_o[i] = bypass ? iq.enq_instr_i[byp_src[i]] : mem_q[rd_idx[i]];
`else
                iq.deq_instr_o[i] = mem_q[rd_idx[i]];
`endif
            end
        end
    end

`ifndef IQ_BYPASS_EN
    // Bypass steering exists only in the bypass build.
    logic unused_bypass;
    assign unused_bypass = bypass ^ (^byp_src);
`endif

    assign iq.enq_ready_o = enq_ready;
    assign iq.deq_valid_o = lane_valid;
    assign count_o        = count;
    assign full_o         = (count == CW'(DEPTH));
    assign empty_o        = (count == '0);

endmodule

// File: tb/tb_multi_issue_instr_queue.sv
// Directed self-checking bench for multi_issue_instr_queue (DEPTH=8, LANES=2).
module tb_multi_issue_instr_queue;
    import drac_pkg::*;

    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          flush_i;
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;

    int checks = 0;
    int errors = 0;

    multi_issue_instr_queue_if #(.LANES(LANES)) iq_if ();

    multi_issue_instr_queue #(
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (flush_i),
        .iq      (iq_if),
        .count_o (count_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        flush;
        logic [1:0]  enq_valid;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic [1:0]  deq_ready;
        int          exp_count;
        logic        exp_ready;
        logic [1:0]  exp_dv;
        logic [63:0] exp_pc0;
        logic [63:0] exp_pc1;
    } vec_t;

    vec_t vecs [$];

    function automatic id_ir_stage_t mk(input logic [63:0] pc);
        id_ir_stage_t t;
        t.pc       = pc;
        t.inst     = {pc[15:0], 16'h0013};
        t.ex_valid = pc[2];
        return t;
    endfunction

    function automatic vec_t v(input string n, input logic fl, input logic [1:0] ev,
                               input logic [63:0] p0, input logic [63:0] p1,
                               input logic [1:0] dr, input int cnt, input logic rdy,
                               input logic [1:0] dv, input logic [63:0] e0,
                               input logic [63:0] e1);
        vec_t r;
        r.name = n; r.flush = fl; r.enq_valid = ev; r.pc0 = p0; r.pc1 = p1;
        r.deq_ready = dr; r.exp_count = cnt; r.exp_ready = rdy; r.exp_dv = dv;
        r.exp_pc0 = e0; r.exp_pc1 = e1;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] ev, input logic [63:0] p0,
                         input logic [63:0] p1, input logic [1:0] dr);
        flush_i               = fl;
        iq_if.enq_valid_i     = ev;
        iq_if.enq_instr_i[0]  = mk(p0);
        iq_if.enq_instr_i[1]  = mk(p1);
        iq_if.deq_ready_i     = dr;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 64'hDEAD_0000, 64'hDEAD_0004, 2'b00);
    endtask

    // Clock the applied inputs in, then observe the registered state with inputs idle.
    task automatic cycle();
        @(posedge clk_i);
        #1;
        idle();
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic rdy,
                               input logic [1:0] dv, input logic [63:0] p0,
                               input logic [63:0] p1);
        id_ir_stage_t e0, e1;
        e0 = dv[0] ? mk(p0) : '0;
        e1 = dv[1] ? mk(p1) : '0;
        check({tag, ".count"}, 128'(count_o), 128'(cnt));
        check({tag, ".full"},  128'(full_o),  128'(cnt == DEPTH));
        check({tag, ".empty"}, 128'(empty_o), 128'(cnt == 0));
        check({tag, ".ready"}, 128'(iq_if.enq_ready_o), 128'(rdy));
        check({tag, ".dv"},    128'(iq_if.deq_valid_o), 128'(dv));
        check({tag, ".instr0"}, 128'(iq_if.deq_instr_o[0]), 128'(e0));
        check({tag, ".instr1"}, 128'(iq_if.deq_instr_o[1]), 128'(e1));
    endtask

    logic [63:0] exp_q [$];
    logic [63:0] next_pc;

    initial begin
        // name, flush, enq_valid, pc0, pc1, deq_ready, count, ready, dv, exp pc0, exp pc1
        vecs.push_back(v("lane1_only",  0, 2'b10, 64'h1F0, 64'h200, 2'b00, 1, 1, 2'b01, 64'h200, 64'h0));
        vecs.push_back(v("push_lane0",  0, 2'b01, 64'h204, 64'h2FC, 2'b00, 2, 1, 2'b11, 64'h200, 64'h204));
        vecs.push_back(v("deq_gap",     0, 2'b00, 64'h0,   64'h0,   2'b10, 2, 1, 2'b11, 64'h200, 64'h204));
        vecs.push_back(v("deq_both",    0, 2'b00, 64'h0,   64'h0,   2'b11, 0, 1, 2'b00, 64'h0,   64'h0));
        vecs.push_back(v("fill_a",      0, 2'b11, 64'h300, 64'h304, 2'b00, 2, 1, 2'b11, 64'h300, 64'h304));
        vecs.push_back(v("fill_b",      0, 2'b11, 64'h308, 64'h30C, 2'b00, 4, 1, 2'b11, 64'h300, 64'h304));
        vecs.push_back(v("fill_c",      0, 2'b01, 64'h310, 64'h314, 2'b00, 5, 1, 2'b11, 64'h300, 64'h304));
        vecs.push_back(v("flush",       1, 2'b11, 64'h400, 64'h404, 2'b00, 0, 1, 2'b00, 64'h0,   64'h0));
        vecs.push_back(v("after_flush", 0, 2'b11, 64'h500, 64'h504, 2'b00, 2, 1, 2'b11, 64'h500, 64'h504));
        vecs.push_back(v("pop_one",     0, 2'b00, 64'h0,   64'h0,   2'b01, 1, 1, 2'b01, 64'h504, 64'h0));
        vecs.push_back(v("push_pop",    0, 2'b11, 64'h508, 64'h50C, 2'b01, 2, 1, 2'b11, 64'h508, 64'h50C));
        vecs.push_back(v("fill_d",      0, 2'b11, 64'h510, 64'h514, 2'b00, 4, 1, 2'b11, 64'h508, 64'h50C));
        vecs.push_back(v("fill_e",      0, 2'b11, 64'h518, 64'h51C, 2'b00, 6, 1, 2'b11, 64'h508, 64'h50C));
        vecs.push_back(v("fill_f",      0, 2'b01, 64'h520, 64'h524, 2'b00, 7, 0, 2'b11, 64'h508, 64'h50C));
        vecs.push_back(v("rejected",    0, 2'b11, 64'h600, 64'h604, 2'b00, 7, 0, 2'b11, 64'h508, 64'h50C));
        vecs.push_back(v("pop2_noenq",  0, 2'b11, 64'h608, 64'h60C, 2'b11, 5, 1, 2'b11, 64'h510, 64'h514));
        vecs.push_back(v("pop_lane0",   0, 2'b00, 64'h0,   64'h0,   2'b01, 4, 1, 2'b11, 64'h514, 64'h518));
        vecs.push_back(v("pop_wrap",    0, 2'b00, 64'h0,   64'h0,   2'b11, 2, 1, 2'b11, 64'h51C, 64'h520));
        vecs.push_back(v("drain",       0, 2'b00, 64'h0,   64'h0,   2'b11, 0, 1, 2'b00, 64'h0,   64'h0));

        rstn_i = 1'b0;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        check_state("reset", 0, 1'b1, 2'b00, 64'h0, 64'h0);
        rstn_i = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].flush, vecs[k].enq_valid, vecs[k].pc0, vecs[k].pc1, vecs[k].deq_ready);
            cycle();
            check_state(vecs[k].name, vecs[k].exp_count, vecs[k].exp_ready, vecs[k].exp_dv,
                        vecs[k].exp_pc0, vecs[k].exp_pc1);
        end

        // Reset wins over flush and a live handshake.
        drive(1'b0, 2'b11, 64'h900, 64'h904, 2'b00);
        cycle();
        rstn_i = 1'b0;
        drive(1'b1, 2'b11, 64'h908, 64'h90C, 2'b11);
        @(posedge clk_i);
        #1;
        idle();
        #1;
        check_state("reset_busy", 0, 1'b1, 2'b00, 64'h0, 64'h0);
        rstn_i = 1'b1;

        // Fill to full; readiness drops once fewer than LANES entries remain.
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 2'b01, 64'h100 + 64'(4 * k), 64'hBAD, 2'b00);
            cycle();
            check_state("fill_single", k + 1, (k + 1) <= 6, (k == 0) ? 2'b01 : 2'b11,
                        64'h100, 64'h104);
        end
        drive(1'b0, 2'b11, 64'h118, 64'h11C, 2'b00);
        cycle();
        check_state("full", 8, 1'b0, 2'b11, 64'h100, 64'h104);
        drive(1'b0, 2'b11, 64'h700, 64'h704, 2'b00);
        cycle();
        check_state("full_hold", 8, 1'b0, 2'b11, 64'h100, 64'h104);

        // Pop from full (push is not credited), then steady 2-in/2-out across wrap.
        drive(1'b0, 2'b11, 64'h708, 64'h70C, 2'b11);
        cycle();
        check_state("full_pop", 6, 1'b1, 2'b11, 64'h108, 64'h10C);
        for (int k = 0; k < 6; k++) exp_q.push_back(64'h108 + 64'(4 * k));
        next_pc = 64'h120;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 2'b11, next_pc, next_pc + 64'h4, 2'b11);
            cycle();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back(next_pc);
            exp_q.push_back(next_pc + 64'h4);
            next_pc = next_pc + 64'h8;
            check_state("steady", 6, 1'b1, 2'b11, exp_q[0], exp_q[1]);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
            cycle();
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            if (exp_q.size() > 0) check_state("drain_model", exp_q.size(), 1'b1, 2'b11, exp_q[0], exp_q[1]);
            else                  check_state("drain_model", 0, 1'b1, 2'b00, 64'h0, 64'h0);
        end

`ifdef IQ_BYPASS_EN
        // Empty queue: lane 0 is consumed combinationally, lane 1 lands in storage.
        drive(1'b0, 2'b11, 64'h800, 64'h804, 2'b01);
        #1;
        check("byp.dv",     128'(iq_if.deq_valid_o),    128'(2'b11));
        check("byp.instr0", 128'(iq_if.deq_instr_o[0]), 128'(mk(64'h800)));
        cycle();
        check_state("byp_after", 1, 1'b1, 2'b01, 64'h804, 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
